// File: rtl/dmem_pkg.sv
// Shared types and constants for the data_mem_port block.
// even_parity is only referenced when DMEM_PARITY_EN is defined.
package dmem_pkg;

    localparam int DMEM_DATA_W = 20;
    localparam int DMEM_ADDR_W = 8;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    // Even-parity bit: makes the XOR over {parity, data} zero.
    // Callers zero-extend narrower words, which leaves parity unchanged.
    function automatic logic even_parity(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM with write-first registered read.
// zero_i forces the read register to 0 for cycles that must not return data.
module dmem_array #(
    parameter int WIDTH = 20,
    parameter int AW    = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic             zero_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [2**AW];
    logic [WIDTH-1:0] rdata_q;

    // Contents are deliberately not reset; the owner clears them if needed.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (zero_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= we_i ? wdata_i : mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_port.sv
// Word-addressed data memory behind the processor's memory stage: zero-fill after
// reset, then one access per clock with a sticky range check. Macro DMEM_PARITY_EN adds ParityErr.
module data_mem_port
    import dmem_pkg::*;
#(
    parameter int DATA_W         = DMEM_DATA_W,
    parameter int ADDR_W         = DMEM_ADDR_W,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [DATA_W-1:0] Daddress,
    input  logic [DATA_W-1:0] Dout,
    input  logic              W,
    output logic [DATA_W-1:0] DataIn,
    output logic              Ready,
`ifdef DMEM_PARITY_EN
    output logic              ParityErr,
`endif
    output logic              AddrErr
);

`ifdef DMEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              ready_q;
    logic              addr_err_q, addr_err_d;
    logic              in_range;

    logic              arr_we;
    logic              arr_zero;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] data_w;
    logic [MEM_W-1:0]  arr_wdata;
    logic [MEM_W-1:0]  arr_rdata;

    assign in_range = ((Daddress >> ADDR_W) == '0);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= CLEAR_ON_RESET ? CLEAR : RUN;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_q    <= (state_d == RUN);
            addr_err_q <= addr_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_err_d = addr_err_q;
        arr_we     = 1'b0;
        arr_zero   = 1'b1;
        arr_addr   = Daddress[ADDR_W-1:0];
        data_w     = Dout;
        case (state_q)
            CLEAR: begin
                // Processor inputs are ignored until the fill completes.
                arr_we   = 1'b1;
                arr_addr = cnt_q;
                data_w   = '0;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                arr_zero = ~in_range;
                arr_we   = W & in_range;
                if (!in_range) begin
                    addr_err_d = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

`ifdef DMEM_PARITY_EN
    logic rd_chk_q;

    assign arr_wdata = {even_parity(64'(data_w)), data_w};

    // Only genuine array reads are checked; forwarded write data is trusted.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rd_chk_q <= 1'b0;
        end else begin
            rd_chk_q <= (state_q == RUN) & in_range & ~W;
        end
    end

    assign ParityErr = rd_chk_q & (^arr_rdata);
`else
    assign arr_wdata = data_w;
`endif

    dmem_array #(
        .WIDTH (MEM_W),
        .AW    (ADDR_W)
    ) u_array (
        .clk_i   (Clock),
        .rst_ni  (Reset),
        .we_i    (arr_we),
        .zero_i  (arr_zero),
        .addr_i  (arr_addr),
        .wdata_i (arr_wdata),
        .rdata_o (arr_rdata)
    );

    assign DataIn  = arr_rdata[DATA_W-1:0];
    assign Ready   = ready_q;
    assign AddrErr = addr_err_q;

endmodule

// File: tb/tb_data_mem_port.sv
// Self-checking bench for data_mem_port: directed scenarios plus random traffic
// checked against an array-based reference model.
module tb_data_mem_port;

    localparam int DW    = 20;
    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          Clock;
    logic          Reset;
    logic [DW-1:0] Daddress;
    logic [DW-1:0] Dout;
    logic          W;
    logic [DW-1:0] DataIn;
    logic          Ready;
    logic          AddrErr;
`ifdef DMEM_PARITY_EN
    logic          ParityErr;
`endif

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] model [DEPTH];
    logic          err_model;

    data_mem_port #(
        .DATA_W         (DW),
        .ADDR_W         (AW),
        .CLEAR_ON_RESET (1'b1)
    ) u_dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Daddress (Daddress),
        .Dout     (Dout),
        .W        (W),
        .DataIn   (DataIn),
        .Ready    (Ready),
`ifdef DMEM_PARITY_EN
        .ParityErr(ParityErr),
`endif
        .AddrErr  (AddrErr)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Drive one access away from the edge, then sample 1 time unit after the edge.
    task automatic op(input logic w, input logic [DW-1:0] a, input logic [DW-1:0] d);
        @(negedge Clock);
        W = w;
        Daddress = a;
        Dout = d;
        @(posedge Clock);
        #1;
    endtask

    // Apply the model's view of one access and return the expected DataIn.
    function automatic logic [DW-1:0] model_access(input logic w, input logic [DW-1:0] a,
                                                   input logic [DW-1:0] d);
        if (a >= DW'(DEPTH)) begin
            err_model = 1'b1;
            return '0;
        end
        if (w) begin
            model[a[AW-1:0]] = d;
            return d;
        end
        return model[a[AW-1:0]];
    endfunction

    // Count edges after release until Ready rises; the fill itself zeroes the model.
    task automatic release_and_count(output int cycles);
        @(negedge Clock);
        Reset = 1'b1;
        cycles = 0;
        while (cycles < 400) begin
            @(posedge Clock);
            #1;
            cycles++;
            if (Ready) break;
        end
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        err_model = 1'b0;
    endtask

    task automatic test_reset;
        W = 1'b0; Daddress = '0; Dout = '0;
        Reset = 1'b0;
        #12;
        checks++; if (DataIn !== '0) begin errors++; $display("FAIL reset_datain got=%h want=0", DataIn); end
        checks++; if (Ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b want=0", Ready); end
        checks++; if (AddrErr !== 1'b0) begin errors++; $display("FAIL reset_addrerr got=%b want=0", AddrErr); end
    endtask

    task automatic test_clear;
        int cyc;
        logic [DW-1:0] addrs [3];
        addrs[0] = 20'h00000; addrs[1] = 20'h0007F; addrs[2] = 20'h000FF;
        // Garbage on the processor inputs during the fill must not matter.
        W = 1'b1; Daddress = 20'h00033; Dout = 20'hFFFFF;
        release_and_count(cyc);
        checks++; if (cyc != DEPTH) begin errors++; $display("FAIL clear_cycles got=%0d want=%0d", cyc, DEPTH); end
        for (int i = 0; i < 3; i++) begin
            op(1'b0, addrs[i], 20'h55555);
            checks++;
            if (DataIn !== '0) begin errors++; $display("FAIL clear_read addr=%h got=%h want=0", addrs[i], DataIn); end
        end
        op(1'b0, 20'h00033, '0);
        checks++; if (DataIn !== '0) begin errors++; $display("FAIL clear_ignores_w got=%h want=0", DataIn); end
    endtask

    task automatic test_write_read;
        logic [DW-1:0] exp;
        op(1'b1, 20'h00012, 20'hABCDE);
        exp = model_access(1'b1, 20'h00012, 20'hABCDE);
        op(1'b0, 20'h00012, 20'h00000);
        exp = model_access(1'b0, 20'h00012, 20'h00000);
        checks++; if (DataIn !== 20'hABCDE) begin errors++; $display("FAIL write_then_read got=%h want=abcde", DataIn); end
        checks++; if (Ready !== 1'b1) begin errors++; $display("FAIL run_ready got=%b want=1", Ready); end
        @(negedge Clock);
        checks++; if (DataIn !== exp) begin errors++; $display("FAIL read_hold got=%h want=%h", DataIn, exp); end
    endtask

    task automatic test_write_first;
        logic [DW-1:0] exp;
        op(1'b1, 20'h00005, 20'h12345);
        exp = model_access(1'b1, 20'h00005, 20'h12345);
        checks++; if (DataIn !== 20'h12345) begin errors++; $display("FAIL write_first got=%h want=12345", DataIn); end
        op(1'b0, 20'h00005, '0);
        exp = model_access(1'b0, 20'h00005, '0);
        checks++; if (DataIn !== exp) begin errors++; $display("FAIL write_first_readback got=%h want=%h", DataIn, exp); end
    endtask

    task automatic test_out_of_range;
        logic [DW-1:0] exp;
        op(1'b0, 20'h00000, '0);
        checks++; if (AddrErr !== 1'b0) begin errors++; $display("FAIL addrerr_before got=%b want=0", AddrErr); end
        op(1'b1, 20'h00100, 20'hFFFFF);
        exp = model_access(1'b1, 20'h00100, 20'hFFFFF);
        checks++; if (AddrErr !== 1'b1) begin errors++; $display("FAIL oor_addrerr got=%b want=1", AddrErr); end
        checks++; if (DataIn !== '0) begin errors++; $display("FAIL oor_datain got=%h want=0", DataIn); end
        op(1'b0, 20'h00000, '0);
        exp = model_access(1'b0, 20'h00000, '0);
        checks++; if (DataIn !== exp) begin errors++; $display("FAIL oor_no_write got=%h want=%h", DataIn, exp); end
        checks++; if (AddrErr !== 1'b1) begin errors++; $display("FAIL oor_sticky got=%b want=1", AddrErr); end
    endtask

    task automatic test_random;
        logic          w;
        logic [DW-1:0] a, d, exp;
        int            bad;
        bad = 0;
        for (int n = 0; n < 300; n++) begin
            w = 1'($urandom_range(0, 1));
            d = DW'($urandom);
            if ($urandom_range(0, 7) == 0)
                a = DW'(($urandom_range(1, 4095) << AW) | $urandom_range(0, 255));
            else
                a = DW'($urandom_range(0, 15) + (($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : 0));
            op(w, a, d);
            exp = model_access(w, a, d);
            checks++;
            if (DataIn !== exp || AddrErr !== err_model || Ready !== 1'b1) begin
                errors++;
                if (bad++ < 10)
                    $display("FAIL random n=%0d w=%b a=%h got=%h/%b want=%h/%b", n, w, a, DataIn, AddrErr, exp, err_model);
            end
        end
    endtask

    task automatic test_reset_mid_clear;
        int cyc;
        Reset = 1'b0;
        #7;
        @(negedge Clock);
        Reset = 1'b1;
        repeat (100) @(posedge Clock);
        #3;
        Reset = 1'b0;
        #1;
        checks++; if (Ready !== 1'b0 || DataIn !== '0 || AddrErr !== 1'b0) begin
            errors++; $display("FAIL midclear_reset got=%b/%h/%b want=0/0/0", Ready, DataIn, AddrErr);
        end
        release_and_count(cyc);
        checks++; if (cyc != DEPTH) begin errors++; $display("FAIL midclear_cycles got=%0d want=%0d", cyc, DEPTH); end
        op(1'b0, 20'h000C8, '0);
        checks++; if (DataIn !== '0) begin errors++; $display("FAIL midclear_read got=%h want=0", DataIn); end
    endtask

`ifdef DMEM_PARITY_EN
    task automatic test_parity;
        op(1'b1, 20'h00020, 20'h00001);
        checks++; if (ParityErr !== 1'b0) begin errors++; $display("FAIL parity_fwd got=%b want=0", ParityErr); end
        u_dut.u_array.mem[32][DW] = ~u_dut.u_array.mem[32][DW];
        op(1'b0, 20'h00020, '0);
        checks++; if (ParityErr !== 1'b1 || DataIn !== 20'h00001) begin
            errors++; $display("FAIL parity_flag got=%b/%h want=1/00001", ParityErr, DataIn);
        end
        op(1'b0, 20'h00021, '0);
        checks++; if (ParityErr !== 1'b0) begin errors++; $display("FAIL parity_pulse got=%b want=0", ParityErr); end
    endtask
`endif

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        err_model = 1'b0;
        test_reset;
        test_clear;
        test_write_read;
        test_write_first;
        test_out_of_range;
        test_random;
        test_reset_mid_clear;
`ifdef DMEM_PARITY_EN
        test_parity;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_port.md
Name: data_mem_port

Overview:
- Word-addressed synchronous data memory that sits directly downstream of pipelineProcessor's memory-access stage.
- Consumes the processor's Daddress, Dout and W every cycle, and returns read data on DataIn, which feeds the processor's DataIn input.
- After reset it runs a self-clearing sequence, then serves one access per clock, with an address-range checker.

Parameters:
- DATA_W, 20: data word width; matches the processor datapath.
- ADDR_W, 8: implemented address bits; memory holds 2**ADDR_W words.
- CLEAR_ON_RESET, 1: when 1, zero-fill the memory after reset; when 0, skip the fill.

Ports:
- Clock  in  1  single system clock; rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Daddress  in  DATA_W  word address from the processor; only bits [ADDR_W-1:0] index the array.
- Dout  in  DATA_W  write data from the processor.
- W  in  1  write enable; 1 = store Dout at Daddress this cycle.
- DataIn  out  DATA_W  registered read data to the processor.
- Ready  out  1  1 once the memory is serving accesses (state RUN).
- AddrErr  out  1  sticky flag: an out-of-range address was presented while in RUN.

Behaviour:
- Reset (Reset=0, asynchronous):
  - DataIn=0, Ready=0, AddrErr=0, clear counter=0.
  - State=CLEAR if CLEAR_ON_RESET=1, else RUN.
  - Array contents are not reset by the reset signal itself.
- Asserting Reset mid-CLEAR aborts the fill; after release the fill restarts at address 0.
- State CLEAR:
  - Each rising edge writes 0 to mem[cnt] and increments cnt.
  - After writing address 2**ADDR_W-1 (counter wraps to 0), state becomes RUN on that same edge.
  - Fill takes exactly 2**ADDR_W cycles.
  - While in CLEAR: W, Daddress and Dout are ignored; DataIn holds 0; Ready=0; AddrErr is not updated.
- State RUN:
  - Ready=1 (registered, rises on the edge that enters RUN).
  - Every rising edge samples Daddress, Dout and W.
- In range (Daddress[DATA_W-1:ADDR_W]==0):
  - If W=1: mem[a] <= Dout.
  - DataIn <= (W ? Dout : mem[a]). Write-first: a read-during-write to the same address returns the new data.
  - Read latency is 1 cycle: data for the address sampled at edge N is visible after edge N and stable until edge N+1.
- Out of range (any upper bit set):
  - The write is suppressed and the array is unchanged.
  - DataIn <= 0.
  - AddrErr <= 1, and it stays 1 until Reset.
- Back-to-back accesses are allowed every cycle with no stalls.
  - A write at edge N followed by a read of the same address at edge N+1 returns the written data.
- RUN is terminal; only Reset leaves it.
- There is no X-propagation onto DataIn after CLEAR. With CLEAR_ON_RESET=0, reads of never-written words are undefined.

Optional Feature:
- Macro DMEM_PARITY_EN.
- Defined:
  - The array stores DATA_W+1 bits per word; the extra bit is the even-parity bit of the data, written alongside every write, including CLEAR writes.
  - An extra output ParityErr (out, 1) pulses high for one cycle, aligned with DataIn, when a RUN read (W=0, in range) returns a word whose stored parity mismatches.
  - ParityErr resets to 0.
  - Write-first forwarded data never flags.
- Not defined:
  - The array is DATA_W wide.
  - The ParityErr port does not exist.
  - Behaviour is otherwise identical.

Decomposition:
- Package dmem_pkg holds:
  - State enum {CLEAR, RUN}.
  - Default DATA_W=20 and ADDR_W=8 constants.
  - Parity helper function (used only under DMEM_PARITY_EN).
- One sub-module, dmem_array: a single-port synchronous RAM with write-first registered read, parameterized by width and depth.
  - The top holds the FSM, clear counter, range check, AddrErr and parity logic.

Test Plan:
- Reset release, CLEAR_ON_RESET=1, ADDR_W=8:
  - Ready=0 for exactly 256 cycles, then 1.
  - Reads of addresses 0, 0x7F and 0xFF return 0x00000.
- RUN: write 0xABCDE to address 0x12, then read 0x12 the next cycle:
  - DataIn=0xABCDE one cycle after the read is sampled.
- Same-cycle read/write: W=1, Daddress=0x05, Dout=0x12345:
  - DataIn=0x12345 after that edge (write-first).
- Out of range: W=1, Daddress=0x00100, Dout=0xFFFFF:
  - AddrErr goes 1 and stays 1; DataIn=0; mem[0x00] is unchanged (still reads 0).
- Reset pulse asserted 100 cycles into CLEAR:
  - Outputs return to reset values immediately.
  - After release, Ready rises a full 256 cycles later.
- With DMEM_PARITY_EN: write 0x00001 to 0x20, force a flip of the stored parity bit, read 0x20:
  - ParityErr=1 for exactly one cycle, with DataIn=0x00001.
